// File: rtl/fpaddsub_pkg.sv
// Shared widths, opcode constants and the B-operand builder for the FP
// add/sub mantissa execute stage.
package fpaddsub_pkg;

  localparam int MW_DEFAULT = 25;
  localparam int EXT_W      = MW_DEFAULT + 3;
  localparam int SUM_W      = MW_DEFAULT + 1;
  localparam int MAX_MW     = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Builds {Mmin_hi, G, R, S} for any mantissa width up to MAX_MW-1. The
  // caller zero-extends Mmin to 2*MAX_MW bits and keeps the low mw+3 bits.
  function automatic logic [MAX_MW+2:0] build_b(input logic [2*MAX_MW-1:0] mmin,
                                                input int mw);
    logic [MAX_MW+2:0] b;
    logic              sticky;
    b      = '0;
    sticky = 1'b0;
    for (int i = 0; i < MAX_MW; i++) begin
      if (i < mw) b[i+3] = mmin[i+mw];
    end
    b[2] = mmin[mw-1];
    b[1] = mmin[mw-2];
    for (int i = 0; i < 2*MAX_MW; i++) begin
      if (i < mw - 2) sticky = sticky | mmin[i];
    end
    b[0] = sticky;
    return b;
  endfunction

endpackage

// File: rtl/fpaddsub_grs_adder.sv
// Combinational add/sub over MW+3 extended operands; subtract returns the
// magnitude and flags a borrow as Neg.
module fpaddsub_grs_adder
  import fpaddsub_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic [MW+2:0] a,
  input  logic [MW+2:0] b,
  input  logic          opr,
  output logic [MW:0]   sum,
  output logic          g,
  output logic          r,
  output logic          s,
  output logic          neg,
  output logic          zero
);

  logic [MW+3:0] diff;
  logic [MW+3:0] res;

  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    neg  = 1'b0;
    if (opr == OP_ADD) begin
      res = {1'b0, a} + {1'b0, b};
    end else if (diff[MW+3]) begin
      res = -diff;
      neg = 1'b1;
    end else begin
      res = diff;
    end
    sum  = res[MW+3:3];
    g    = res[2];
    r    = res[1];
    s    = res[0];
    zero = (res == '0);
  end

endmodule

// File: rtl/fpaddsub_execute_pipe.sv
// Pipelined mantissa add/sub execute stage with G/R/S tracking, elastic
// valid/ready flow control and a passthrough tag.
module fpaddsub_execute_pipe
  import fpaddsub_pkg::*;
#(
  parameter int MW     = MW_DEFAULT,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MW-1:0]    Mmax,
  input  logic [2*MW-1:0]  Mmin,
  input  logic             Smax,
  input  logic             Smin,
  input  logic             OpMode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW:0]      Sum,
  output logic             Cout,
  output logic             GuardBit,
  output logic             RoundBit,
  output logic             StickyBit,
  output logic             Opr,
  output logic             Neg,
  output logic             Zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int AW = MW + 3;

  // Handshake: a beat moves on a clock edge when valid and ready are both
  // high; a stage loads whenever it is empty or its downstream is loading.
  logic [AW-1:0]         a_in, b_in, a_x, b_x;
  logic [MAX_MW+2:0]     b_full;
  logic [2*MAX_MW-1:0]   mmin_ext;
  logic                  b_unused;
  logic                  opr_in, opr_x, v_x, en_out;
  logic [TAG_W-1:0]      tag_x;

  always_comb begin
    mmin_ext           = '0;
    mmin_ext[2*MW-1:0] = Mmin;
    b_full             = build_b(mmin_ext, MW);
  end

  assign a_in     = {Mmax, 3'b000};
  assign b_in     = b_full[AW-1:0];
  assign b_unused = ^b_full[MAX_MW+2:AW];
  assign opr_in   = Smax ^ Smin ^ OpMode;

  logic          v_out;
  logic [MW:0]   sum_c, sum_q;
  logic          g_c, r_c, s_c, neg_c, zero_c;
  logic          g_q, r_q, s_q, neg_q, zero_q, opr_q;
  logic [TAG_W-1:0] tag_q;

  assign en_out = ~v_out | out_ready;

  if (MW >= MAX_MW) begin : g_bad_mw
    $error("MW must be below MAX_MW");
  end

  if (STAGES == 2) begin : g_two
    logic             v1, opr1;
    logic [AW-1:0]    a1, b1;
    logic [TAG_W-1:0] tag1;
    logic             en_s1;

    assign en_s1    = ~v1 | en_out;
    assign in_ready = en_s1 & ~rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1   <= 1'b0;
        opr1 <= 1'b0;
        a1   <= '0;
        b1   <= '0;
        tag1 <= '0;
      end else if (en_s1) begin
        v1 <= in_valid;
        if (in_valid) begin
          opr1 <= opr_in;
          a1   <= a_in;
          b1   <= b_in;
          tag1 <= in_tag;
        end
      end
    end

    assign v_x   = v1;
    assign a_x   = a1;
    assign b_x   = b1;
    assign opr_x = opr1;
    assign tag_x = tag1;
  end else if (STAGES == 1) begin : g_one
    assign in_ready = en_out & ~rst;
    assign v_x      = in_valid;
    assign a_x      = a_in;
    assign b_x      = b_in;
    assign opr_x    = opr_in;
    assign tag_x    = in_tag;
  end else begin : g_bad_stages
    $error("STAGES must be 1 or 2");
  end

  fpaddsub_grs_adder #(.MW(MW)) u_adder (
    .a    (a_x),
    .b    (b_x),
    .opr  (opr_x),
    .sum  (sum_c),
    .g    (g_c),
    .r    (r_c),
    .s    (s_c),
    .neg  (neg_c),
    .zero (zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v_out  <= 1'b0;
      sum_q  <= '0;
      g_q    <= 1'b0;
      r_q    <= 1'b0;
      s_q    <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      opr_q  <= 1'b0;
      tag_q  <= '0;
    end else if (en_out) begin
      v_out <= v_x;
      if (v_x) begin
        sum_q  <= sum_c;
        g_q    <= g_c;
        r_q    <= r_c;
        s_q    <= s_c;
        neg_q  <= neg_c;
        zero_q <= zero_c;
        opr_q  <= opr_x;
        tag_q  <= tag_x;
      end
    end
  end

  assign out_valid = v_out;
  assign Sum       = sum_q;
  assign Cout      = sum_q[MW];
  assign GuardBit  = g_q;
  assign RoundBit  = r_q;
  assign StickyBit = s_q;
  assign Opr       = opr_q;
  assign Neg       = neg_q;
  assign Zero      = zero_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_fpaddsub_execute_pipe.sv
// Bench for fpaddsub_execute_pipe: directed spec vectors, backpressure,
// randomized streaming and mid-flight reset against an arithmetic model.
module tb_fpaddsub_execute_pipe;

  localparam int MW     = 25;
  localparam int STAGES = 2;
  localparam int TAG_W  = 8;
  localparam int EW     = TAG_W + 7 + MW + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MW-1:0]    mmax = '0;
  logic [2*MW-1:0]  mmin = '0;
  logic             smax = 1'b0, smin = 1'b0, opmode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [MW:0]      sum;
  logic             cout, guard_bit, round_bit, sticky_bit, opr, neg, zero;
  logic [TAG_W-1:0] out_tag;

  fpaddsub_execute_pipe #(.MW(MW), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Mmax      (mmax),
    .Mmin      (mmin),
    .Smax      (smax),
    .Smin      (smin),
    .OpMode    (opmode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Cout      (cout),
    .GuardBit  (guard_bit),
    .RoundBit  (round_bit),
    .StickyBit (sticky_bit),
    .Opr       (opr),
    .Neg       (neg),
    .Zero      (zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic          ov, ir, acc;
  logic [EW-1:0] obs, expv;

  // Reference: extend to MW+3 bits, add, or subtract returning |A-B|.
  function automatic logic [EW-1:0] model(input logic [MW-1:0] xmax,
                                          input logic [2*MW-1:0] xmin,
                                          input logic sa, input logic sb,
                                          input logic op,
                                          input logic [TAG_W-1:0] tag);
    longint a, b, res;
    logic   e_opr, e_neg;
    logic [MW:0] e_sum;
    a = longint'(xmax) * 8;
    b = longint'(xmin[2*MW-1:MW]) * 8 + longint'(xmin[MW-1]) * 4 +
        longint'(xmin[MW-2]) * 2 + ((xmin[MW-3:0] != 0) ? 1 : 0);
    e_opr = sa ^ sb ^ op;
    e_neg = 1'b0;
    if (!e_opr) res = a + b;
    else if (a >= b) res = a - b;
    else begin
      res   = b - a;
      e_neg = 1'b1;
    end
    e_sum = res[MW+3:3];
    return {tag, e_opr, e_neg, (res == 0), e_sum[MW], res[2], res[1], res[0], e_sum};
  endfunction

  task automatic drive_cycle(input logic iv, input logic [MW-1:0] xmax,
                             input logic [2*MW-1:0] xmin, input logic sa,
                             input logic sb, input logic op,
                             input logic [TAG_W-1:0] tag, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    mmax      = xmax;
    mmin      = xmin;
    smax      = sa;
    smin      = sb;
    opmode    = op;
    in_tag    = tag;
    out_ready = ordy;
    #1;
    ov   = out_valid;
    ir   = in_ready;
    obs  = {out_tag, opr, neg, zero, cout, guard_bit, round_bit, sticky_bit, sum};
    acc  = iv && ir;
    expv = model(xmax, xmin, sa, sb, op, tag);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
    end
    vectors++;
    obs = {out_tag, opr, neg, zero, cout, guard_bit, round_bit, sticky_bit, sum};
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h required 0", obs);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic test_directed();
    logic [MW-1:0]   t_max[6];
    logic [2*MW-1:0] t_min[6];
    logic [2:0]      t_sso[6];
    logic [MW:0]     t_sum[6];
    t_max = '{25'h1200000, 25'h1800000, 25'h1000000, 25'h1600000, 25'h1000000, 25'h0800000};
    t_min = '{{25'h0C00000, 25'h0}, {25'h0800000, 25'h0}, {25'h1000000, 25'h0},
              {25'h0400000, 25'h0}, 50'd1, {25'h1000000, 25'h0}};
    t_sso = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b001};
    t_sum = '{26'h1E00000, 26'h2000000, 26'h0, 26'h1200000, 26'h0FFFFFF, 26'h0800000};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, t_max[i], t_min[i], t_sso[i][2], t_sso[i][1], t_sso[i][0], 8'(i), 1'b1);
      vectors++;
      if (acc !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_accept[%0d] in_ready=%b required 1", i, ir);
      end
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      vectors++;
      if (ov !== 1'b0) begin
        miscompares++;
        $display("FAIL dir_latency_early[%0d] out_valid=%b required 0", i, ov);
      end
      expv = model(t_max[i], t_min[i], t_sso[i][2], t_sso[i][1], t_sso[i][0], 8'(i));
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      expv = model(t_max[i], t_min[i], t_sso[i][2], t_sso[i][1], t_sso[i][0], 8'(i));
      vectors++;
      if (ov !== 1'b1 || obs !== expv) begin
        miscompares++;
        $display("FAIL dir_result[%0d] valid=%b got %h required %h", i, ov, obs, expv);
      end
      vectors++;
      if (obs[MW:0] !== t_sum[i]) begin
        miscompares++;
        $display("FAIL dir_sum[%0d] got %h required %h", i, obs[MW:0], t_sum[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    logic        ordy, exp_ir;
    logic [63:0] r64;
    for (int cyc = 0; cyc < 60 && (sent < 6 || exp_q.size() > 0); cyc++) begin
      ordy = (cyc % 3 == 0);
      r64  = {$urandom, $urandom};
      drive_cycle(sent < 6, 25'($urandom), r64[2*MW-1:0], 1'($urandom), 1'($urandom),
                  1'($urandom), 8'(sent), ordy);
      exp_ir = (exp_q.size() < STAGES) || ordy;
      vectors++;
      if (ir !== exp_ir) begin
        miscompares++;
        $display("FAIL bp_in_ready cyc=%0d got %b required %b", cyc, ir, exp_ir);
      end
      if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_spurious got %h required none", obs);
        end else begin
          if (obs !== exp_q[0]) begin
            miscompares++;
            $display("FAIL bp_output cyc=%0d got %h required %h", cyc, obs, exp_q[0]);
          end
          if (ordy) void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        exp_q.push_back(expv);
        sent++;
      end
    end
    vectors++;
    if (sent != 6 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain sent=%0d pending=%0d required 6/0", sent, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [63:0]   r64;
    logic [MW-1:0] xmax;
    logic [2*MW-1:0] xmin;
    logic          ordy, iv;
    int            tagc = 0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      iv   = (cyc < 300) && ($urandom_range(0, 3) != 0);
      ordy = (cyc >= 300) || ($urandom_range(0, 3) != 0);
      xmax = 25'($urandom);
      r64  = {$urandom, $urandom};
      xmin = r64[2*MW-1:0];
      if ($urandom_range(0, 3) == 0) xmin[2*MW-1:MW] = xmax;
      drive_cycle(iv, xmax, xmin, 1'($urandom), 1'($urandom), 1'($urandom), 8'(tagc), ordy);
      if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious got %h required none", obs);
        end else begin
          if (obs !== exp_q[0]) begin
            miscompares++;
            $display("FAIL rnd_output cyc=%0d got %h required %h", cyc, obs, exp_q[0]);
          end
          if (ordy) void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        exp_q.push_back(expv);
        tagc++;
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 25'h1200000, {25'h0100000, 25'h0}, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_fill0 in_ready=%b required 1", ir);
    end
    drive_cycle(1'b1, 25'h1300000, {25'h0200000, 25'h0}, 1'b0, 1'b0, 1'b1, 8'hF1, 1'b0);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_fill1 in_ready=%b required 1", ir);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid out_valid=%b required 0", out_valid);
    end
    exp_q.delete();
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_cycle(cyc < 4, 25'h1000000 + 25'(cyc), {25'(cyc * 3), 25'h1ABCDE}, 1'b0,
                  1'b0, cyc[0], 8'h10 + 8'(cyc), 1'b1);
      if (ov) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL flush_ghost got %h required none", obs);
        end else begin
          if (obs !== exp_q[0]) begin
            miscompares++;
            $display("FAIL flush_output got %h required %h", obs, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (acc) exp_q.push_back(expv);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL flush_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpaddsub_execute_pipe.md
Name: fpaddsub_execute_pipe

Overview:
Parametrised, pipelined successor to the combinational mantissa execute stage of the FP adder/subtractor. Takes the aligned larger mantissa (Mmax) and the double-width shifted smaller mantissa (Mmin), forms the effective operation from both signs and OpMode, and adds or subtracts at full guard/round/sticky precision. Produces Sum, Cout, G/R/S bits, and Neg/Zero flags. Sits between the alignment/shift stage and the normaliser, with valid/ready handshakes on both sides and a sideband tag carried through.

Parameters:
MW, 25, width of Mmax (hidden bit + fraction + 1 headroom); Mmin is 2*MW, Sum is MW+1
STAGES, 2, pipeline depth: 1 or 2; any other value is a synthesis error
TAG_W, 8, width of the passthrough tag

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
Mmax  in  MW  larger aligned mantissa
Mmin  in  2*MW  smaller mantissa; upper MW bits aligned to Mmax, lower MW bits shifted out
Smax  in  1  sign of larger operand
Smin  in  1  sign of smaller operand
OpMode  in  1  0 = add, 1 = subtract
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
Sum  out  MW+1  result magnitude; bit MW is the carry
Cout  out  1  equals Sum[MW]
GuardBit, RoundBit, StickyBit  out  1 each  result G/R/S
Opr  out  1  effective operation: Smax^Smin^OpMode (1 = subtract)
Neg  out  1  effective subtract produced a negative result; magnitude is returned in Sum
Zero  out  1  Sum, G, R and S are all zero
out_tag  out  TAG_W  tag of this result

Behaviour:
- Single clock domain clk; reset rst is synchronous and active-high. It clears every stage valid and drives all outputs to 0. in_ready is 0 while rst is high.
- Extended operands are MW+3 bits wide. A = {Mmax,3'b000}. B = {Mmin[2MW-1:MW], Mmin[MW-1], Mmin[MW-2], |Mmin[MW-3:0]}.
- Opr=0: R = A + B, computed MW+4 bits wide.
- Opr=1: R = A - B. If the result is negative (borrow), Neg=1 and R becomes the two's complement magnitude.
- Outputs from R: Sum = R[MW+3:3]; G = R[2]; R bit = R[1]; S = R[0]; Neg is forced to 0 when Opr=0.
- Subtraction is exact over the G/R/S bits. A borrow from the sticky bit propagates into Sum.
- Pipeline, STAGES=2:
  - Stage 1 registers Opr, A and B, and the tag.
  - Stage 2 registers the add/sub result and the flags.
  - Latency is 2 cycles from an accepted input beat to out_valid.
- STAGES=1: a single register after the combinational adder; latency is 1 cycle.
- Handshake:
  - A beat is accepted when in_valid and in_ready are both high. A beat is delivered when out_valid and out_ready are both high.
  - Each stage k has an enable: en[k] = ~v[k] | en[k+1], with en[STAGES] = out_ready. in_ready = en[0].
  - Bubbles collapse. With out_ready held high, throughput is 1 beat per cycle.
- Under stall (out_ready=0), all outputs hold stable while out_valid=1. No beat is dropped or duplicated.
- Simultaneous accept and deliver in the same cycle at a full pipe: both happen, and occupancy is unchanged.
- Reset mid-operation flushes every in-flight beat. The first out_valid after reset belongs to a beat accepted after reset.
- Data registers are loaded only on a stage enable together with a valid upstream beat. Output values while out_valid=0 are don't-care, apart from the reset value of 0.

Decomposition:
- Package fpaddsub_pkg holds:
  - the default MW (25) and the derived widths EXT_W=MW+3 and SUM_W=MW+1;
  - the opcode constants OP_ADD=0 and OP_SUB=1;
  - a function that builds B, including the sticky OR-reduction.
- One sub-module, fpaddsub_grs_adder: a combinational (MW+3)-bit add/sub with a magnitude/negate result. It outputs Sum, G, R, S, Neg and Zero, and is instantiated once before the final register.

Test Plan:
1. Basic add. Inputs (MW=25): Mmax=0x1200000, Mmin=0x0C00000<<25, Smax=Smin=OpMode=0. Response: after 2 cycles Sum=0x1E00000, Cout=0, G=R=S=0, Opr=0.
2. Add with carry. Inputs: Mmax=0x1800000, Mmin=0x0800000<<25, all signs/mode 0. Response: Sum=0x2000000, Cout=1.
3. Sign-driven subtract to zero. Inputs: Mmax=0x1000000, Mmin=0x1000000<<25, Smin=1. Response: Opr=1, Sum=0, Zero=1, Neg=0. A second beat with OpMode=1 and Mmax=0x1600000, Mmin=0x0400000<<25 gives Sum=0x1200000.
4. Exact sticky borrow. Inputs: Mmax=0x1000000, Mmin=1, OpMode=1. Response: Sum=0x0FFFFFF, G=1, R=1, S=1, Cout=0.
5. Negative result. Inputs: Mmax=0x0800000, Mmin=0x1000000<<25, OpMode=1. Response: Neg=1, Sum=0x0800000.
6. Backpressure and reset.
   - Stimulus: stream 6 tagged beats 0..5 with out_ready toggling 1,0,0,1,...
   - Response: tags arrive in order with no loss or duplication, outputs hold stable while stalled, and in_ready=0 when both stages are full and out_ready=0.
   - Then assert rst for 1 cycle with 2 beats in flight. Response: out_valid=0 the next cycle, and neither flushed beat is ever delivered.
